uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_rx_cfg.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver with ready/valid output and a sticky overrun flag.
// Optional feature macro UART_RX_CFG_MAJORITY_EN: 3-sample majority vote per bit plus a noise flag.
module uart_rx_cfg #(
    parameter int P_DATA_BITS_MAX = 9,
    parameter int P_DIV_WIDTH     = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       enable_i,
    input  logic                       data_i,
    input  logic [P_DIV_WIDTH-1:0]     div_i,
    input  logic [3:0]                 data_bits_i,
    input  logic                       parity_en_i,
    input  logic                       parity_sel_i,
    input  logic                       stop2_i,
    input  logic                       ready_i,
    output logic [P_DATA_BITS_MAX-1:0] data_o,
    output logic                       valid_o,
    output logic                       busy_o,
    output logic                       parity_err_o,
    output logic                       framing_err_o,
    output logic                       break_o,
    output logic                       noise_err_o,
    output logic                       overrun_err_o
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_HIGH = 3'd5;

    localparam logic [P_DIV_WIDTH-1:0] LP_DIV_MIN  = P_DIV_WIDTH'(4);
    localparam logic [3:0]             LP_BITS_MIN = 4'd5;
    localparam logic [3:0]             LP_BITS_MAX = 4'(P_DATA_BITS_MAX);

    logic                       r_sync1, r_sync2;
    logic [2:0]                 r_state;
    logic [P_DIV_WIDTH-1:0]     r_div, r_cnt;
    logic [3:0]                 r_nbits, r_bit_cnt;
    logic                       r_par_en, r_par_sel, r_stop2;
    logic [P_DATA_BITS_MAX-1:0] r_shadow, r_data;
    logic                       r_par_acc, r_perr, r_ferr, r_all_zero;
    logic                       r_valid, r_perr_o, r_ferr_o, r_brk_o, r_ovr;

    logic                       w_rx, w_start_go, w_cnt_last, w_sample, w_bit;
    logic                       w_last_stop, w_done, w_hs, w_load;
    logic [P_DIV_WIDTH-1:0]     w_half, w_div_clamp;
    logic [3:0]                 w_bits_clamp;

    assign w_rx         = r_sync2;
    assign w_half       = r_div >> 1;
    assign w_cnt_last   = (r_cnt == r_div - 1'b1);
    assign w_start_go   = (r_state == S_IDLE) && enable_i && !w_rx;
    assign w_div_clamp  = (div_i < LP_DIV_MIN) ? LP_DIV_MIN : div_i;
    assign w_bits_clamp = (data_bits_i < LP_BITS_MIN) ? LP_BITS_MIN :
                          (data_bits_i > LP_BITS_MAX) ? LP_BITS_MAX : data_bits_i;
    assign w_last_stop  = (r_bit_cnt == {3'b000, r_stop2});
    assign w_done       = (r_state == S_STOP) && w_sample && w_last_stop;
    assign w_hs         = r_valid && ready_i;
    assign w_load       = w_done && (!r_valid || ready_i);

`ifdef UART_RX_CFG_MAJORITY_EN
    logic r_s0, r_s1, r_noise, r_noise_o;
    logic w_noise_bit, w_in_bit;

    // Decision is made on the third sample; the first two are held until then.
    assign w_sample    = (r_cnt == w_half + 1'b1);
    assign w_bit       = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
    assign w_noise_bit = !((r_s0 == r_s1) && (r_s1 == w_rx));
    assign w_in_bit    = (r_state == S_START) || (r_state == S_DATA) ||
                         (r_state == S_PARITY) || (r_state == S_STOP);
    assign noise_err_o = r_noise_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_s0      <= 1'b1;
            r_s1      <= 1'b1;
            r_noise   <= 1'b0;
            r_noise_o <= 1'b0;
        end else begin
            if (w_in_bit && r_cnt == w_half - 1'b1) r_s0 <= w_rx;
            if (w_in_bit && r_cnt == w_half)        r_s1 <= w_rx;
            if (w_start_go)
                r_noise <= 1'b0;
            else if (w_in_bit && w_sample)
                r_noise <= r_noise | w_noise_bit;
            if (w_load) r_noise_o <= r_noise | w_noise_bit;
        end
    end
`else
    assign w_sample    = (r_cnt == w_half);
    assign w_bit       = w_rx;
    assign noise_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= data_i;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_div      <= LP_DIV_MIN;
            r_nbits    <= LP_BITS_MIN;
            r_par_en   <= 1'b0;
            r_par_sel  <= 1'b0;
            r_stop2    <= 1'b0;
            r_shadow   <= '0;
            r_par_acc  <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_all_zero <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_go) begin
                        // The detection cycle itself counts as count 0 of the start bit.
                        r_state    <= S_START;
                        r_cnt      <= P_DIV_WIDTH'(1);
                        r_bit_cnt  <= '0;
                        r_div      <= w_div_clamp;
                        r_nbits    <= w_bits_clamp;
                        r_par_en   <= parity_en_i;
                        r_par_sel  <= parity_sel_i;
                        r_stop2    <= stop2_i;
                        r_shadow   <= '0;
                        r_par_acc  <= 1'b0;
                        r_perr     <= 1'b0;
                        r_ferr     <= 1'b0;
                        r_all_zero <= 1'b1;
                    end
                end
                S_START: begin
                    r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
                    if (w_sample && w_bit) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (w_cnt_last) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
                    if (w_sample) begin
                        for (int unsigned i = 0; i < P_DATA_BITS_MAX; i++)
                            if (4'(i) == r_bit_cnt) r_shadow[i] <= w_bit;
                        r_par_acc <= r_par_acc ^ w_bit;
                        if (w_bit) r_all_zero <= 1'b0;
                    end
                    if (w_cnt_last) begin
                        if (r_bit_cnt == r_nbits - 1'b1) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
                    if (w_sample) begin
                        r_perr <= (w_bit != (r_par_acc ^ r_par_sel));
                        if (w_bit) r_all_zero <= 1'b0;
                    end
                    if (w_cnt_last) r_state <= S_STOP;
                end
                S_STOP: begin
                    r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
                    if (w_sample) begin
                        if (!w_bit) r_ferr <= 1'b1;
                        else        r_all_zero <= 1'b0;
                    end
                    if (w_done) begin
                        r_state <= w_bit ? S_IDLE : S_WAIT_HIGH;
                        r_cnt   <= '0;
                    end else if (w_cnt_last) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (w_rx) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A completion that coincides with a handshake replaces the word instead of overrunning.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_perr_o <= 1'b0;
            r_ferr_o <= 1'b0;
            r_brk_o  <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            if (w_load) begin
                r_data   <= r_shadow;
                r_valid  <= 1'b1;
                r_perr_o <= r_perr;
                r_ferr_o <= r_ferr | ~w_bit;
                r_brk_o  <= r_all_zero & ~w_bit;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
            if (w_done && r_valid && !ready_i)
                r_ovr <= 1'b1;
            else if (w_hs)
                r_ovr <= 1'b0;
        end
    end

    assign data_o        = r_data;
    assign valid_o       = r_valid;
    assign busy_o        = (r_state != S_IDLE);
    assign parity_err_o  = r_perr_o;
    assign framing_err_o = r_ferr_o;
    assign break_o       = r_brk_o;
    assign overrun_err_o = r_ovr;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: table of frames plus hand-written corner sequences; every received
// word is checked against a scoreboard queue at its valid/ready handshake.
module tb_uart_rx_cfg;
`ifdef UART_RX_CFG_MAJORITY_EN
    localparam int DEC = 1;
`else
    localparam int DEC = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        line = 1'b1;
    logic [15:0] div = 16'd16;
    logic [3:0]  dbits = 4'd8;
    logic        pen = 1'b0, psel = 1'b0, stop2 = 1'b0, ready = 1'b1;
    logic [8:0]  dout;
    logic        valid, busy, perr, ferr, brk, noise, ovr;

    uart_rx_cfg #(.P_DATA_BITS_MAX(9), .P_DIV_WIDTH(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(en), .data_i(line), .div_i(div),
        .data_bits_i(dbits), .parity_en_i(pen), .parity_sel_i(psel), .stop2_i(stop2),
        .ready_i(ready), .data_o(dout), .valid_o(valid), .busy_o(busy),
        .parity_err_o(perr), .framing_err_o(ferr), .break_o(brk),
        .noise_err_o(noise), .overrun_err_o(ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] data;
        logic       perr, ferr, brk, noise;
    } exp_t;

    typedef struct {
        int         cdiv;
        logic [3:0] cbits;
        int         ldiv;
        int         lbits;
        bit         pe, ps, s2;
        logic [8:0] w;
        bit         badp, bads;
        logic [8:0] xd;
        bit         xp, xf, xb;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [8:0] d, input bit p, input bit f, input bit b, input bit n);
        exp_t e;
        e.data = d; e.perr = p; e.ferr = f; e.brk = b; e.noise = n;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: a word is consumed on the edge after valid & ready is seen.
    initial begin
        forever begin : mon
            exp_t e;
            @(negedge clk);
            if (rst_n && valid && ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h required=none", dout);
                end else begin
                    e = sb.pop_front();
                    check("word_data", dout, e.data);
                    check("word_flags", {perr, ferr, brk, noise}, {e.perr, e.ferr, e.brk, e.noise});
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_bit(input logic b, input int d);
        line = b;
        tick(d);
    endtask

    task automatic set_cfg(input int d, input logic [3:0] b, input bit pe, input bit ps, input bit s2);
        div = 16'(d); dbits = b; pen = pe; psel = ps; stop2 = s2;
    endtask

    task automatic send_frame(input int d, input int nb, input logic [8:0] w, input bit pe,
                              input bit ps, input bit badp, input int ns, input bit bads);
        logic par;
        par = ps ^ badp;
        send_bit(1'b0, d);
        // Configuration is already latched; scramble it to show mid-frame changes are ignored.
        div = 16'($urandom); dbits = 4'($urandom); pen = 1'($urandom);
        psel = 1'($urandom); stop2 = 1'($urandom);
        for (int i = 0; i < nb; i++) begin
            par = par ^ w[i];
            send_bit(w[i], d);
        end
        if (pe) send_bit(par, d);
        for (int i = 0; i < ns; i++) send_bit(!bads, d);
        line = 1'b1;
    endtask

    vec_t tbl[10];
    logic [8:0] wv;

    initial begin
        tbl[0] = '{16, 4'd8,  16, 8, 1'b0, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{16, 4'd7,  16, 7, 1'b1, 1'b1, 1'b1, 9'h035, 1'b1, 1'b0, 9'h035, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{16, 4'd7,  16, 7, 1'b1, 1'b1, 1'b1, 9'h035, 1'b0, 1'b0, 9'h035, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{2,  4'd5,  4,  5, 1'b1, 1'b0, 1'b0, 9'h01F, 1'b0, 1'b0, 9'h01F, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{8,  4'd3,  8,  5, 1'b0, 1'b0, 1'b0, 9'h016, 1'b0, 1'b0, 9'h016, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{8,  4'd15, 8,  9, 1'b0, 1'b0, 1'b1, 9'h1C3, 1'b0, 1'b0, 9'h1C3, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{8,  4'd9,  8,  9, 1'b1, 1'b0, 1'b0, 9'h155, 1'b0, 1'b0, 9'h155, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{10, 4'd6,  10, 6, 1'b0, 1'b0, 1'b0, 9'h02A, 1'b0, 1'b1, 9'h02A, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{6,  4'd8,  6,  8, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{4,  4'd8,  4,  8, 1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 1'b1, 9'h000, 1'b0, 1'b1, 1'b1};

        // Reset state
        tick(3);
        check("reset_outputs", {dout, valid, busy, perr, ferr, brk, noise, ovr}, 0);
        rst_n = 1'b1;
        tick(3);

        // 8N1 0xA5 at div 16: valid must rise exactly one cycle after the stop sample
        set_cfg(16, 4'd8, 1'b0, 1'b0, 1'b0);
        push(9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0);
        wv = 9'h0A5;
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(wv[i], 16);
        line = 1'b1;
        tick(10 + DEC);
        check("valid_before_stop_sample", valid, 1'b0);
        tick(1);
        check("valid_after_stop_sample", valid, 1'b1);
        tick(10);

        for (int k = 0; k < 10; k++) begin
            set_cfg(tbl[k].cdiv, tbl[k].cbits, tbl[k].pe, tbl[k].ps, tbl[k].s2);
            push(tbl[k].xd, tbl[k].xp, tbl[k].xf, tbl[k].xb, 1'b0);
            send_frame(tbl[k].ldiv, tbl[k].lbits, tbl[k].w, tbl[k].pe, tbl[k].ps,
                       tbl[k].badp, tbl[k].s2 ? 2 : 1, tbl[k].bads);
            tick(3 * tbl[k].ldiv);
        end
        check("table_all_consumed", sb.size(), 0);

        // Overrun: two 9-bit frames back to back with ready low
        ready = 1'b0;
        push(9'h1A5, 1'b0, 1'b0, 1'b0, 1'b0);
        set_cfg(8, 4'd9, 1'b0, 1'b0, 1'b0);
        send_frame(8, 9, 9'h1A5, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        set_cfg(8, 4'd9, 1'b0, 1'b0, 1'b0);
        send_frame(8, 9, 9'h0F3, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        tick(20);
        check("ovr_valid_held", valid, 1'b1);
        check("ovr_first_word_held", dout, 9'h1A5);
        check("ovr_flag_set", ovr, 1'b1);
        ready = 1'b1;
        tick(1);
        check("ovr_cleared_by_handshake", ovr, 1'b0);
        check("ovr_valid_dropped", valid, 1'b0);
        tick(5);

        // Completion in the same cycle as a handshake: new word loaded, no overrun
        ready = 1'b0;
        push(9'h03C, 1'b0, 1'b0, 1'b0, 1'b0);
        push(9'h0C3, 1'b0, 1'b0, 1'b0, 1'b0);
        set_cfg(8, 4'd8, 1'b0, 1'b0, 1'b0);
        fork
            begin
                send_frame(8, 8, 9'h03C, 1'b0, 1'b0, 1'b0, 1, 1'b0);
                set_cfg(8, 4'd8, 1'b0, 1'b0, 1'b0);
                send_frame(8, 8, 9'h0C3, 1'b0, 1'b0, 1'b0, 1, 1'b0);
            end
            begin
                tick(158 + DEC);
                ready = 1'b1;
                tick(1);
                ready = 1'b0;
            end
        join
        tick(5);
        check("coincide_valid_high", valid, 1'b1);
        check("coincide_no_overrun", ovr, 1'b0);
        ready = 1'b1;
        tick(3);

        // Break: line low for 15 bit times at 8N1
        set_cfg(8, 4'd8, 1'b0, 1'b0, 1'b0);
        push(9'h000, 1'b0, 1'b1, 1'b1, 1'b0);
        line = 1'b0;
        tick(8 * 15);
        check("break_busy_while_low", busy, 1'b1);
        line = 1'b1;
        tick(4);
        check("break_idle_after_high", busy, 1'b0);

        // Enable low keeps the receiver in IDLE
        en = 1'b0;
        line = 1'b0;
        tick(20);
        check("disabled_stays_idle", busy, 1'b0);
        line = 1'b1;
        tick(5);
        en = 1'b1;

        // Short start pulse
        set_cfg(16, 4'd8, 1'b0, 1'b0, 1'b0);
        line = 1'b0;
        tick(4);
        line = 1'b1;
        tick(2);
        check("glitch_start_busy", busy, 1'b1);
        tick(30);
        check("glitch_start_idle", busy, 1'b0);
        check("glitch_start_no_valid", valid, 1'b0);

        // Reset in the middle of DATA while a word is pending
        ready = 1'b0;
        set_cfg(8, 4'd8, 1'b0, 1'b0, 1'b0);
        send_frame(8, 8, 9'h05A, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        tick(5);
        check("pre_reset_word", {valid, dout}, {1'b1, 9'h05A});
        set_cfg(16, 4'd8, 1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        send_bit(1'b0, 8);
        rst_n = 1'b0;
        #1;
        check("reset_mid_data", {dout, valid, busy, perr, ferr, brk, noise, ovr}, 0);
        line = 1'b1;
        tick(2);
        rst_n = 1'b1;
        ready = 1'b1;
        tick(5);
        check("after_reset_idle", busy, 1'b0);

        set_cfg(8, 4'd8, 1'b0, 1'b0, 1'b0);
        push(9'h066, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8, 8, 9'h066, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        tick(20);

`ifdef UART_RX_CFG_MAJORITY_EN
        // One-cycle glitch at the centre of data bit 2
        set_cfg(16, 4'd8, 1'b0, 1'b0, 1'b0);
        push(9'h0A5, 1'b0, 1'b0, 1'b0, 1'b1);
        wv = 9'h0A5;
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                line = wv[i];  tick(8);
                line = !wv[i]; tick(1);
                line = wv[i];  tick(7);
            end else begin
                send_bit(wv[i], 16);
            end
        end
        send_bit(1'b1, 16);
        tick(20);
`endif

        check("all_words_consumed", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
